vga_grid_renderer: RTL and testbench
====================================

// Module: vga_grid_renderer
// PURPOSE
//  Parametrised board renderer for VGA 640x480@60 (25 MHz pixel clock): draws ROWS x COLS grid, per-cell player markers,
//  blinking cursor and win-line highlight. Sits between game logic (board state, cursor) and VGA pins.
//  Replaces fixed 5x5 combinational renderer: incremental cell counters (no divide/modulo), frame-latched board
//  snapshot (no tearing), 2-stage registered colour pipeline with sync aligned.
// PARAMETERS
//  ROWS 5 board rows | COLS 5 board columns | STATE_W 2 bits per cell state | IDX_W 3 cursor index width
//  CELL_W 128 cell width px | CELL_H 96 cell height px | LINE_T 3 grid line thickness px | PAD 16 marker inset px
//  HPIXELS 800 | VLINES 521 | HPULSE 96 | VPULSE 2 | HBP 144 | HFP 784 | VBP 31 | VFP 511 (VGA timing, counter units)
//  BLINK_FRAMES 30 frames per cursor blink half-period
// PORTS
//  clk_display  in   1                  pixel clock, all logic on rising edge
//  clr_n        in   1                  synchronous reset, active low
//  game_state   in   ROWS*COLS*STATE_W  cell(r,c) at [(r*COLS+c)*STATE_W +: STATE_W]; 0 empty,1 P1,2 P2,3 blocked
//  win_mask     in   ROWS*COLS          bit r*COLS+c set -> cell highlighted as winning
//  cursor_row   in   IDX_W              cursor row
//  cursor_col   in   IDX_W              cursor column
//  cursor_en    in   1                  1 = draw cursor
//  hsync        out  1                  horizontal sync, active low
//  vsync        out  1                  vertical sync, active low
//  red          out  3                  red level
//  green        out  3                  green level
//  blue         out  3                  blue level
//  frame_start  out  1                  1-cycle pulse at hc==0,vc==0 (pre-pipeline timing)
// BEHAVIOUR
//  Reset (clr_n==0 at edge): hc=vc=0, snapshot regs=0, blink counter=0, blink phase=on, pipeline cleared;
//   outputs hsync=1, vsync=1, red=green=blue=0, frame_start=0. Reset mid-frame restarts timing at (0,0) next cycle.
//  Timing: hc 0..HPIXELS-1 wraps to 0, then vc increments, vc wraps 0 after VLINES-1. Raw hsync=(hc>=HPULSE),
//   raw vsync=(vc>=VPULSE). Active area: HBP<=hc<HFP and VBP<=vc<VFP.
//  Cell tracking: col idx cx and offset ox (0..CELL_W-1) cleared at hc==HBP, ox++ per pixel, at CELL_W-1 ox->0,cx++.
//   Row idx cy / offset oy identical per line, cleared at vc==VBP, advanced on hc==HPIXELS-1. No '/' or '%' in RTL.
//  Snapshot: game_state, win_mask, cursor_row/col, cursor_en latched on cycle hc==0,vc==VFP (vertical blank);
//   rendering uses snapshot only; mid-frame input changes appear next frame.
//  Blink: frame counter increments at snapshot point; on reaching BLINK_FRAMES-1 wraps to 0 and toggles phase.
//  Pipeline: stage 1 registers cx,cy,ox,oy,active,in_grid, cell state, win bit, cursor-hit; stage 2 computes and
//   registers colour. hsync/vsync delayed 2 cycles -> colour and sync aligned; latency 2 cycles from (hc,vc).
//  Colour priority (stage 2), first match wins:
//   1 not active -> 000/000/000
//   2 active but cx>=COLS or cy>=ROWS -> black
//   3 ox<LINE_T, ox>=CELL_W-LINE_T, oy<LINE_T or oy>=CELL_H-LINE_T -> black (grid line)
//   4 state 1 and dx*dx+dy*dy<=R*R, dx=ox-CELL_W/2, dy=oy-CELL_H/2 signed, R=min(CELL_W,CELL_H)/2-PAD -> black
//   5 state 2 and PAD<=ox<CELL_W-PAD and PAD<=oy<CELL_H-PAD -> black square
//   6 state 3 in same square -> 111/000/000 red
//   7 win bit -> 000/111/000 green background
//   8 cursor_en, phase on, cx==cursor_col, cy==cursor_row -> 001/100/111 light blue
//   9 else -> 111/111/111 white
//  Arithmetic: dx,dy signed >= clog2(max(CELL_W,CELL_H))+2 bits; squares/sum sized so no overflow.
//  Cursor indices >=COLS/ROWS: no highlight, no error. STATE_W>2: only values 1..3 render, others empty.
// TESTING
//  T1 reset: hold clr_n=0 5 cycles -> hsync=vsync=1, rgb=0; release -> hsync low exactly cycles 2..97 (latency 2).
//  T2 timing: run 2 frames -> hsync period 800, low 96; vsync low 2 lines of 521; frame_start every 416800 cycles.
//  T3 markers: cell(0,0)=1, (1,1)=2, (2,2)=3 -> pixel (hc=144+64,vc=31+48) black; (hc=272+20,vc=127+20) black;
//   (hc=400+20,vc=223+20) red; (hc=144+20,vc=31+20) white; (hc=144+1,any active vc) black line.
//  T4 snapshot: set (0,0)=1 mid-frame at vc=200 -> frame continues white at (208,79); next frame shows black.
//  T5 blink/cursor: cursor (3,4), en=1 -> light blue at (656+20,319+20) frames 0..29, white frames 30..59;
//   cursor_col=7 -> never highlighted.
//  T6 priority: win_mask bit 0 set, cell(0,0)=1, cursor (0,0) -> circle black, background green not blue.

Source files
------------

// File: rtl/vga_grid_renderer.sv
// Board renderer for 640x480@60 VGA: grid lines, per-cell markers, blinking cursor and win highlight.
// Board inputs are captured once per frame in vertical blank; the colour path is two registers deep.
module vga_grid_renderer #(
  parameter int ROWS         = 5,
  parameter int COLS         = 5,
  parameter int STATE_W      = 2,
  parameter int IDX_W        = 3,
  parameter int CELL_W       = 128,
  parameter int CELL_H       = 96,
  parameter int LINE_T       = 3,
  parameter int PAD          = 16,
  parameter int HPIXELS      = 800,
  parameter int VLINES       = 521,
  parameter int HPULSE       = 96,
  parameter int VPULSE       = 2,
  parameter int HBP          = 144,
  parameter int HFP          = 784,
  parameter int VBP          = 31,
  parameter int VFP          = 511,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk_display,
  input  logic                         clr_n,
  input  logic [ROWS*COLS*STATE_W-1:0] game_state,
  input  logic [ROWS*COLS-1:0]         win_mask,
  input  logic [IDX_W-1:0]             cursor_row,
  input  logic [IDX_W-1:0]             cursor_col,
  input  logic                         cursor_en,
  output logic                         hsync,
  output logic                         vsync,
  output logic [2:0]                   red,
  output logic [2:0]                   green,
  output logic [2:0]                   blue,
  output logic                         frame_start
);

  localparam int HCW      = $clog2(HPIXELS);
  localparam int VCW      = $clog2(VLINES);
  localparam int OXW      = $clog2(CELL_W);
  localparam int OYW      = $clog2(CELL_H);
  localparam int CXW      = (IDX_W > $clog2(COLS + 1)) ? IDX_W : $clog2(COLS + 1);
  localparam int CYW      = (IDX_W > $clog2(ROWS + 1)) ? IDX_W : $clog2(ROWS + 1);
  localparam int BCW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW       = $clog2((CELL_W > CELL_H) ? CELL_W : CELL_H) + 2;
  localparam int MIN_CELL = (CELL_W < CELL_H) ? CELL_W : CELL_H;
  localparam int R_PIX    = (MIN_CELL >> 1) - PAD;
  localparam logic [2*DW:0] R_SQ = (2*DW+1)'(R_PIX * R_PIX);

  localparam logic [8:0] RGB_BLACK  = 9'b000_000_000;
  localparam logic [8:0] RGB_RED    = 9'b111_000_000;
  localparam logic [8:0] RGB_GREEN  = 9'b000_111_000;
  localparam logic [8:0] RGB_CURSOR = 9'b001_100_111;
  localparam logic [8:0] RGB_WHITE  = 9'b111_111_111;

  // raster position and cell tracking
  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [OYW-1:0] oy_q, oy_d;
  logic           line_end;

  // per-frame snapshot and blink state
  logic [ROWS*COLS*STATE_W-1:0] state_snap_q, state_snap_d;
  logic [ROWS*COLS-1:0]         win_snap_q, win_snap_d;
  logic [IDX_W-1:0]             crow_snap_q, crow_snap_d;
  logic [IDX_W-1:0]             ccol_snap_q, ccol_snap_d;
  logic                         cen_snap_q, cen_snap_d;
  logic [BCW-1:0]               blink_cnt_q, blink_cnt_d;
  logic                         blink_on_q, blink_on_d;
  logic                         snap_pt;

  // stage 1
  logic               s1_hsync_q, s1_hsync_d;
  logic               s1_vsync_q, s1_vsync_d;
  logic               s1_active_q, s1_active_d;
  logic               s1_in_grid_q, s1_in_grid_d;
  logic [OXW-1:0]     s1_ox_q, s1_ox_d;
  logic [OYW-1:0]     s1_oy_q, s1_oy_d;
  logic [STATE_W-1:0] s1_st_q, s1_st_d;
  logic               s1_win_q, s1_win_d;
  logic               s1_cur_q, s1_cur_d;

  // stage 2 / outputs
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [8:0] rgb_q, rgb_d;
  logic       frame_start_q, frame_start_d;

  logic signed [DW-1:0]   dx, dy;
  logic signed [2*DW-1:0] dx_w, dy_w;
  logic [2*DW:0]          dist_sq;
  logic                   grid_line, in_square, in_circle;

  always_comb begin
    line_end = (hc_q == HCW'(HPIXELS - 1));
    hc_d     = line_end ? '0 : hc_q + HCW'(1);
    vc_d     = vc_q;
    if (line_end) begin
      vc_d = (vc_q == VCW'(VLINES - 1)) ? '0 : vc_q + VCW'(1);
    end

    // Counters describe the pixel currently in hc_q/vc_q, so they reload one step ahead.
    // Cell indices saturate at COLS/ROWS; anything beyond the board renders black anyway.
    cx_d = cx_q;
    ox_d = ox_q;
    if (hc_d == HCW'(HBP)) begin
      cx_d = '0;
      ox_d = '0;
    end else if (ox_q == OXW'(CELL_W - 1)) begin
      ox_d = '0;
      if (cx_q != CXW'(COLS)) cx_d = cx_q + CXW'(1);
    end else begin
      ox_d = ox_q + OXW'(1);
    end

    cy_d = cy_q;
    oy_d = oy_q;
    if (line_end) begin
      if (vc_d == VCW'(VBP)) begin
        cy_d = '0;
        oy_d = '0;
      end else if (oy_q == OYW'(CELL_H - 1)) begin
        oy_d = '0;
        if (cy_q != CYW'(ROWS)) cy_d = cy_q + CYW'(1);
      end else begin
        oy_d = oy_q + OYW'(1);
      end
    end

    frame_start_d = (hc_d == '0) && (vc_d == '0);
  end

  always_comb begin
    snap_pt      = (hc_q == '0) && (vc_q == VCW'(VFP));
    state_snap_d = state_snap_q;
    win_snap_d   = win_snap_q;
    crow_snap_d  = crow_snap_q;
    ccol_snap_d  = ccol_snap_q;
    cen_snap_d   = cen_snap_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    if (snap_pt) begin
      state_snap_d = game_state;
      win_snap_d   = win_mask;
      crow_snap_d  = cursor_row;
      ccol_snap_d  = cursor_col;
      cen_snap_d   = cursor_en;
      if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end
  end

  always_comb begin
    s1_hsync_d   = (hc_q >= HCW'(HPULSE));
    s1_vsync_d   = (vc_q >= VCW'(VPULSE));
    s1_active_d  = (hc_q >= HCW'(HBP)) && (hc_q < HCW'(HFP)) &&
                   (vc_q >= VCW'(VBP)) && (vc_q < VCW'(VFP));
    s1_in_grid_d = (cx_q < CXW'(COLS)) && (cy_q < CYW'(ROWS));
    s1_ox_d      = ox_q;
    s1_oy_d      = oy_q;
    s1_st_d      = '0;
    s1_win_d     = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((cy_q == CYW'(r)) && (cx_q == CXW'(c))) begin
          s1_st_d  = state_snap_q[(r*COLS + c)*STATE_W +: STATE_W];
          s1_win_d = win_snap_q[r*COLS + c];
        end
      end
    end
    s1_cur_d = cen_snap_q && blink_on_q &&
               (cx_q == CXW'(ccol_snap_q)) && (cy_q == CYW'(crow_snap_q));
  end

  always_comb begin
    dx      = $signed(DW'(s1_ox_q)) - $signed(DW'(CELL_W >> 1));
    dy      = $signed(DW'(s1_oy_q)) - $signed(DW'(CELL_H >> 1));
    dx_w    = (2*DW)'(dx);
    dy_w    = (2*DW)'(dy);
    dist_sq = (2*DW+1)'($unsigned(dx_w * dx_w)) + (2*DW+1)'($unsigned(dy_w * dy_w));
    in_circle = (dist_sq <= R_SQ);
    grid_line = (s1_ox_q < OXW'(LINE_T)) || (s1_ox_q >= OXW'(CELL_W - LINE_T)) ||
                (s1_oy_q < OYW'(LINE_T)) || (s1_oy_q >= OYW'(CELL_H - LINE_T));
    in_square = (s1_ox_q >= OXW'(PAD)) && (s1_ox_q < OXW'(CELL_W - PAD)) &&
                (s1_oy_q >= OYW'(PAD)) && (s1_oy_q < OYW'(CELL_H - PAD));

    hsync_d = s1_hsync_q;
    vsync_d = s1_vsync_q;
    if (!s1_active_q)                                     rgb_d = RGB_BLACK;
    else if (!s1_in_grid_q)                               rgb_d = RGB_BLACK;
    else if (grid_line)                                   rgb_d = RGB_BLACK;
    else if ((s1_st_q == STATE_W'(1)) && in_circle)       rgb_d = RGB_BLACK;
    else if ((s1_st_q == STATE_W'(2)) && in_square)       rgb_d = RGB_BLACK;
    else if ((s1_st_q == STATE_W'(3)) && in_square)       rgb_d = RGB_RED;
    else if (s1_win_q)                                    rgb_d = RGB_GREEN;
    else if (s1_cur_q)                                    rgb_d = RGB_CURSOR;
    else                                                  rgb_d = RGB_WHITE;
  end

  always_ff @(posedge clk_display) begin
    if (!clr_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      ox_q          <= '0;
      oy_q          <= '0;
      state_snap_q  <= '0;
      win_snap_q    <= '0;
      crow_snap_q   <= '0;
      ccol_snap_q   <= '0;
      cen_snap_q    <= 1'b0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      s1_hsync_q    <= 1'b1;
      s1_vsync_q    <= 1'b1;
      s1_active_q   <= 1'b0;
      s1_in_grid_q  <= 1'b0;
      s1_ox_q       <= '0;
      s1_oy_q       <= '0;
      s1_st_q       <= '0;
      s1_win_q      <= 1'b0;
      s1_cur_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      state_snap_q  <= state_snap_d;
      win_snap_q    <= win_snap_d;
      crow_snap_q   <= crow_snap_d;
      ccol_snap_q   <= ccol_snap_d;
      cen_snap_q    <= cen_snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      s1_hsync_q    <= s1_hsync_d;
      s1_vsync_q    <= s1_vsync_d;
      s1_active_q   <= s1_active_d;
      s1_in_grid_q  <= s1_in_grid_d;
      s1_ox_q       <= s1_ox_d;
      s1_oy_q       <= s1_oy_d;
      s1_st_q       <= s1_st_d;
      s1_win_q      <= s1_win_d;
      s1_cur_q      <= s1_cur_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign red         = rgb_q[8:6];
  assign green       = rgb_q[5:3];
  assign blue        = rgb_q[2:0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Bench for vga_grid_renderer on a shrunken raster: every cycle the output word is compared
// against a pixel model computed directly from raster position with division/modulo.
module tb_vga_grid_renderer;

  localparam int ROWS = 5, COLS = 5, STATE_W = 2, IDX_W = 3;
  localparam int CELL_W = 10, CELL_H = 8, LINE_T = 2, PAD = 2;
  localparam int HPIXELS = 76, VLINES = 54, HPULSE = 4, VPULSE = 1;
  localparam int HBP = 8, HFP = 68, VBP = 3, VFP = 51;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME = HPIXELS * VLINES;

  logic                         clk_display = 1'b0;
  logic                         clr_n;
  logic [ROWS*COLS*STATE_W-1:0] game_state;
  logic [ROWS*COLS-1:0]         win_mask;
  logic [IDX_W-1:0]             cursor_row, cursor_col;
  logic                         cursor_en;
  logic                         hsync, vsync, frame_start;
  logic [2:0]                   red, green, blue;

  always #5 clk_display = ~clk_display;

  vga_grid_renderer #(
    .ROWS(ROWS), .COLS(COLS), .STATE_W(STATE_W), .IDX_W(IDX_W),
    .CELL_W(CELL_W), .CELL_H(CELL_H), .LINE_T(LINE_T), .PAD(PAD),
    .HPIXELS(HPIXELS), .VLINES(VLINES), .HPULSE(HPULSE), .VPULSE(VPULSE),
    .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk_display(clk_display), .clr_n(clr_n), .game_state(game_state), .win_mask(win_mask),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_en(cursor_en),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model: s = raster step held by the DUT counters since reset release
  int                           s;
  logic [ROWS*COLS*STATE_W-1:0] m_state;
  logic [ROWS*COLS-1:0]         m_win;
  int                           m_row, m_col, m_snaps;
  logic                         m_en;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] pix_color(input int hc, input int vc);
    int x, y, cx, cy, ox, oy, dx, dy, st, r;
    bit in_sq, blink_on;
    if (hc < HBP || hc >= HFP || vc < VBP || vc >= VFP) return 9'b000_000_000;
    x  = hc - HBP;
    y  = vc - VBP;
    cx = x / CELL_W;
    ox = x % CELL_W;
    cy = y / CELL_H;
    oy = y % CELL_H;
    if (cx >= COLS || cy >= ROWS) return 9'b000_000_000;
    if (ox < LINE_T || ox >= CELL_W - LINE_T || oy < LINE_T || oy >= CELL_H - LINE_T)
      return 9'b000_000_000;
    st = int'(m_state[(cy*COLS + cx)*STATE_W +: STATE_W]);
    dx = ox - CELL_W / 2;
    dy = oy - CELL_H / 2;
    r  = ((CELL_W < CELL_H) ? CELL_W : CELL_H) / 2 - PAD;
    in_sq = (ox >= PAD && ox < CELL_W - PAD && oy >= PAD && oy < CELL_H - PAD);
    if (st == 1 && dx*dx + dy*dy <= r*r) return 9'b000_000_000;
    if (st == 2 && in_sq) return 9'b000_000_000;
    if (st == 3 && in_sq) return 9'b111_000_000;
    if (m_win[cy*COLS + cx]) return 9'b000_111_000;
    blink_on = ((m_snaps / BLINK_FRAMES) % 2) == 0;
    if (m_en && blink_on && cx == m_col && cy == m_row) return 9'b001_100_111;
    return 9'b111_111_111;
  endfunction

  // {hsync, vsync, frame_start, rgb}; colour and sync trail the counters by two cycles
  function automatic logic [11:0] expect_vec(input int step);
    int p, hc, vc;
    logic fs;
    fs = (step > 0) && (step % FRAME == 0);
    p  = step - 2;
    if (p < 0) return {1'b1, 1'b1, fs, 9'b0};
    hc = p % HPIXELS;
    vc = (p / HPIXELS) % VLINES;
    return {(hc >= HPULSE), (vc >= VPULSE), fs, pix_color(hc, vc)};
  endfunction

  task automatic tick();
    @(posedge clk_display);
    if (!clr_n) begin
      s       = 0;
      m_state = '0;
      m_win   = '0;
      m_row   = 0;
      m_col   = 0;
      m_en    = 1'b0;
      m_snaps = 0;
    end else begin
      if ((s % HPIXELS) == 0 && ((s / HPIXELS) % VLINES) == VFP) begin
        m_state = game_state;
        m_win   = win_mask;
        m_row   = int'(cursor_row);
        m_col   = int'(cursor_col);
        m_en    = cursor_en;
        m_snaps++;
      end
      s++;
    end
    @(negedge clk_display);
    check_eq($sformatf("px step=%0d", s), {hsync, vsync, frame_start, red, green, blue},
             expect_vec(s));
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < ROWS*COLS; i++) begin
      game_state[i*STATE_W +: STATE_W] = 2'($urandom_range(0, 3));
      win_mask[i] = ($urandom_range(0, 5) == 0);
    end
    cursor_row = 3'($urandom_range(0, 7));
    cursor_col = 3'($urandom_range(0, 7));
    cursor_en  = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run(input int n, input int chg_period);
    for (int i = 0; i < n; i++) begin
      if (chg_period > 0 && $urandom_range(0, chg_period - 1) == 0) randomize_inputs();
      tick();
    end
  endtask

  task automatic set_cell(input int r, input int c, input logic [1:0] v);
    game_state[(r*COLS + c)*STATE_W +: STATE_W] = v;
  endtask

  initial begin
    clr_n      = 1'b0;
    game_state = '0;
    win_mask   = '0;
    cursor_row = '0;
    cursor_col = '0;
    cursor_en  = 1'b0;
    s          = 0;
    m_state    = '0;
    m_win      = '0;
    m_row      = 0;
    m_col      = 0;
    m_en       = 1'b0;
    m_snaps    = 0;
    repeat (5) tick();

    // markers, cursor blink; the first frame still shows the empty reset snapshot
    clr_n = 1'b1;
    set_cell(0, 0, 2'd1);
    set_cell(1, 1, 2'd2);
    set_cell(2, 2, 2'd3);
    cursor_row = 3'd3;
    cursor_col = 3'd4;
    cursor_en  = 1'b1;
    run(4*FRAME, 0);

    // win highlight beats cursor, circle beats win
    game_state = '0;
    set_cell(0, 0, 2'd1);
    win_mask   = 25'd1;
    cursor_row = 3'd0;
    cursor_col = 3'd0;
    run(2*FRAME, 0);

    // out-of-range cursor column never highlights
    win_mask   = '0;
    cursor_row = 3'd2;
    cursor_col = 3'd7;
    run(FRAME + 137, 0);

    // random boards changing at arbitrary points within frames
    run(3*FRAME, 200);

    // reset mid-frame, then resume
    clr_n = 1'b0;
    repeat (3) tick();
    clr_n = 1'b1;
    run(FRAME + 500, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
